// File: rtl/snake_motion.sv
// Snake game-state engine: latches direction presses, advances the four-segment
// snake on each rising edge of the frame tick, and sequences game-over blanking.
module snake_motion #(
  parameter int GRID_W     = 40,
  parameter int GRID_H     = 30,
  parameter int START_X    = 20,
  parameter int START_Y    = 15,
  parameter int WRAP       = 1,
  parameter int OVER_TICKS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       btnU,
  input  logic       btnD,
  input  logic       btnL,
  input  logic       btnR,
  output logic [5:0] Px1,
  output logic [5:0] Py1,
  output logic [5:0] Px2,
  output logic [5:0] Py2,
  output logic [5:0] Px3,
  output logic [5:0] Py3,
  output logic [5:0] Px4,
  output logic [5:0] Py4,
  output logic       AllBlack,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_OVER = 2'd2} state_e;
  // Opposite directions differ only in bit 0.
  typedef enum logic [1:0] {DIR_U = 2'd0, DIR_D = 2'd1, DIR_L = 2'd2, DIR_R = 2'd3} dir_e;

  localparam int          CW   = $clog2(OVER_TICKS + 1);
  localparam logic [5:0]  XMAX = 6'(GRID_W - 1);
  localparam logic [5:0]  YMAX = 6'(GRID_H - 1);
  localparam logic [5:0]  SX   = 6'(START_X);
  localparam logic [5:0]  SY   = 6'(START_Y);

  state_e         state_q, state_d;
  dir_e           cur_dir_q, cur_dir_d, pend_dir_q, pend_dir_d;
  logic           tick_q;
  logic [CW-1:0]  cnt_q, cnt_d, cnt_inc;
  logic           allblack_q, allblack_d;
  logic [5:0]     x_q [4];
  logic [5:0]     y_q [4];
  logic [5:0]     x_d [4];
  logic [5:0]     y_d [4];

  logic       step, press_vld, at_edge;
  dir_e       press_dir, dir_ref;
  logic [5:0] nx, ny;

  assign step    = tick_in & ~tick_q;
  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    press_vld = 1'b1;
    press_dir = DIR_R;
    case ({btnU, btnD, btnL, btnR})
      4'b1000: press_dir = DIR_U;
      4'b0100: press_dir = DIR_D;
      4'b0010: press_dir = DIR_L;
      4'b0001: press_dir = DIR_R;
      default: press_vld = 1'b0;
    endcase
  end

  // Wrapped neighbour of the head; at_edge flags that the move crossed a border.
  always_comb begin
    nx      = x_q[0];
    ny      = y_q[0];
    at_edge = 1'b0;
    unique case (pend_dir_q)
      DIR_U: if (y_q[0] == 6'd0) begin ny = YMAX; at_edge = 1'b1; end
             else ny = y_q[0] - 6'd1;
      DIR_D: if (y_q[0] == YMAX) begin ny = 6'd0; at_edge = 1'b1; end
             else ny = y_q[0] + 6'd1;
      DIR_L: if (x_q[0] == 6'd0) begin nx = XMAX; at_edge = 1'b1; end
             else nx = x_q[0] - 6'd1;
      DIR_R: if (x_q[0] == XMAX) begin nx = 6'd0; at_edge = 1'b1; end
             else nx = x_q[0] + 6'd1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cur_dir_d  = cur_dir_q;
    pend_dir_d = pend_dir_q;
    cnt_d      = cnt_q;
    x_d        = x_q;
    y_d        = y_q;
    dir_ref    = cur_dir_q;
    case (state_q)
      ST_IDLE: begin
        if (press_vld && (press_dir != dir_e'(cur_dir_q ^ 2'b01))) begin
          pend_dir_d = press_dir;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        if (step) begin
          cur_dir_d = pend_dir_q;
          dir_ref   = pend_dir_q;
          if (at_edge && (WRAP == 0)) begin
            state_d = ST_OVER;
            cnt_d   = '0;
          end else begin
            for (int i = 3; i > 0; i--) begin
              x_d[i] = x_q[i-1];
              y_d[i] = y_q[i-1];
            end
            x_d[0] = nx;
            y_d[0] = ny;
          end
        end
        // A press on a step edge is judged against the direction just taken.
        if (press_vld && (press_dir != dir_e'(dir_ref ^ 2'b01)))
          pend_dir_d = press_dir;
      end
      ST_OVER: begin
        if (step) begin
          if (cnt_inc == CW'(OVER_TICKS)) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            cur_dir_d  = DIR_R;
            pend_dir_d = DIR_R;
            for (int i = 0; i < 4; i++) begin
              x_d[i] = SX - 6'(i);
              y_d[i] = SY;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    allblack_d = (state_d == ST_OVER);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cur_dir_q  <= DIR_R;
      pend_dir_q <= DIR_R;
      tick_q     <= 1'b0;
      cnt_q      <= '0;
      allblack_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        x_q[i] <= SX - 6'(i);
        y_q[i] <= SY;
      end
    end else begin
      state_q    <= state_d;
      cur_dir_q  <= cur_dir_d;
      pend_dir_q <= pend_dir_d;
      tick_q     <= tick_in;
      cnt_q      <= cnt_d;
      allblack_q <= allblack_d;
      x_q        <= x_d;
      y_q        <= y_d;
    end
  end

  assign Px1      = x_q[0];
  assign Py1      = y_q[0];
  assign Px2      = x_q[1];
  assign Py2      = y_q[1];
  assign Px3      = x_q[2];
  assign Py3      = y_q[2];
  assign Px4      = x_q[3];
  assign Py4      = y_q[3];
  assign AllBlack = allblack_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_snake_motion.sv
// Scoreboard bench for snake_motion: a wrapping and a walled instance share
// stimulus; expected snapshots are queued and checked by a separate monitor.
`timescale 1ns/1ps
module tb_snake_motion;

  logic clk = 1'b0;
  logic reset, tick_in, btnU, btnD, btnL, btnR;

  logic [5:0] wx1, wy1, wx2, wy2, wx3, wy3, wx4, wy4;
  logic [5:0] nx1, ny1, nx2, ny2, nx3, ny3, nx4, ny4;
  logic       w_ab, n_ab;
  logic [1:0] w_st, n_st;

  always #5 clk = ~clk;

  snake_motion #(.WRAP(1)) u_w (
    .clk(clk), .reset(reset), .tick_in(tick_in),
    .btnU(btnU), .btnD(btnD), .btnL(btnL), .btnR(btnR),
    .Px1(wx1), .Py1(wy1), .Px2(wx2), .Py2(wy2),
    .Px3(wx3), .Py3(wy3), .Px4(wx4), .Py4(wy4),
    .AllBlack(w_ab), .state_o(w_st)
  );

  snake_motion #(.WRAP(0)) u_n (
    .clk(clk), .reset(reset), .tick_in(tick_in),
    .btnU(btnU), .btnD(btnD), .btnL(btnL), .btnR(btnR),
    .Px1(nx1), .Py1(ny1), .Px2(nx2), .Py2(ny2),
    .Px3(nx3), .Py3(ny3), .Px4(nx4), .Py4(ny4),
    .AllBlack(n_ab), .state_o(n_st)
  );

  typedef struct {
    logic [50:0] v;
    int          dut;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [50:0] mk(int x1, int y1, int x2, int y2, int x3, int y3,
                                     int x4, int y4, int ab, int st);
    return {6'(x1), 6'(y1), 6'(x2), 6'(y2), 6'(x3), 6'(y3), 6'(x4), 6'(y4), 1'(ab), 2'(st)};
  endfunction

  function automatic logic [50:0] hrow(int hx, int y, int ab, int st);
    return mk(hx, y, hx-1, y, hx-2, y, hx-3, y, ab, st);
  endfunction

  function automatic logic [50:0] vcol(int x, int hy, int ab, int st);
    return mk(x, hy, x, hy+1, x, hy+2, x, hy+3, ab, st);
  endfunction

  task automatic chk(int dut, string name, logic [50:0] v);
    exp_t e;
    e.v = v; e.dut = dut; e.name = name;
    q.push_back(e);
  endtask

  task automatic chk2(string name, logic [50:0] v);
    chk(0, name, v);
    chk(1, name, v);
  endtask

  // One clean step: tick_in low for a cycle, then high for exactly the step edge.
  task automatic step();
    @(posedge clk); #1;
    tick_in = 1'b1;
    @(posedge clk); #1;
    tick_in = 1'b0;
  endtask

  task automatic press(logic [3:0] udlr);
    @(posedge clk); #1;
    {btnU, btnD, btnL, btnR} = udlr;
    @(posedge clk); #1;
    {btnU, btnD, btnL, btnR} = 4'b0000;
  endtask

  initial begin : monitor
    exp_t        e;
    logic [50:0] a;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        a = (e.dut == 0) ? {wx1, wy1, wx2, wy2, wx3, wy3, wx4, wy4, w_ab, w_st}
                         : {nx1, ny1, nx2, ny2, nx3, ny3, nx4, ny4, n_ab, n_st};
        n_checks++;
        if (a !== e.v) begin
          n_fail++;
          $display("FAIL %s (wrap=%0d) got x/y=%h ab=%b st=%0d, expected x/y=%h ab=%b st=%0d",
                   e.name, (e.dut == 0), a[50:3], a[2], a[1:0], e.v[50:3], e.v[2], e.v[1:0]);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: stimulus did not complete, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset = 1'b1; tick_in = 1'b0;
    {btnU, btnD, btnL, btnR} = 4'b0000;
    repeat (3) @(posedge clk); #1;
    reset = 1'b0;
    chk2("reset_values", hrow(20, 15, 0, 0));

    repeat (3) step();
    chk2("idle_steps_ignored", hrow(20, 15, 0, 0));
    press(4'b1010);
    chk2("multi_button_ignored", hrow(20, 15, 0, 0));
    press(4'b0010);
    chk2("idle_reverse_ignored", hrow(20, 15, 0, 0));
    press(4'b0001);
    chk2("idle_to_run", hrow(20, 15, 0, 1));

    for (int k = 1; k <= 3; k++) begin
      step();
      chk2($sformatf("run_step%0d", k), hrow(20 + k, 15, 0, 1));
    end

    press(4'b0010); step();
    chk2("run_reverse_ignored", hrow(24, 15, 0, 1));
    press(4'b1000); step();
    chk2("turn_up", mk(24, 14, 24, 15, 23, 15, 22, 15, 0, 1));

    @(posedge clk); #1;
    tick_in = 1'b1;
    @(posedge clk); #1;
    chk2("held_tick_first", mk(24, 13, 24, 14, 24, 15, 23, 15, 0, 1));
    repeat (99) @(posedge clk);
    #1; tick_in = 1'b0;
    chk2("held_tick_single_step", mk(24, 13, 24, 14, 24, 15, 23, 15, 0, 1));

    // Right press on the step edge: the move still goes up, the turn comes next step.
    @(posedge clk); #1;
    tick_in = 1'b1; btnR = 1'b1;
    @(posedge clk); #1;
    tick_in = 1'b0; btnR = 1'b0;
    chk2("press_on_step_uses_old", mk(24, 12, 24, 13, 24, 14, 24, 15, 0, 1));
    step();
    chk2("press_on_step_applied", mk(25, 12, 24, 12, 24, 13, 24, 14, 0, 1));

    repeat (14) step();
    chk2("at_right_edge", hrow(39, 12, 0, 1));
    step();
    chk(0, "wrap_right", mk(0, 12, 39, 12, 38, 12, 37, 12, 0, 1));
    chk(1, "wall_right_over", hrow(39, 12, 1, 2));
    repeat (3) step();
    chk(0, "wrap_continue", hrow(3, 12, 0, 1));
    chk(1, "over_held_3_ticks", hrow(39, 12, 1, 2));
    step();
    chk(0, "wrap_continue2", hrow(4, 12, 0, 1));
    chk(1, "over_restart", hrow(20, 15, 0, 0));

    press(4'b1000);
    chk(0, "run_press_up", hrow(4, 12, 0, 1));
    chk(1, "restart_press_up", hrow(20, 15, 0, 1));
    repeat (12) step();
    chk(0, "at_top_edge", vcol(4, 0, 0, 1));
    chk(1, "climbing", vcol(20, 3, 0, 1));
    step();
    chk(0, "wrap_top", mk(4, 29, 4, 0, 4, 1, 4, 2, 0, 1));
    chk(1, "climbing2", vcol(20, 2, 0, 1));
    repeat (2) step();
    chk(0, "wrap_top_continue", mk(4, 27, 4, 28, 4, 29, 4, 0, 0, 1));
    chk(1, "at_top_wall", vcol(20, 0, 0, 1));
    step();
    chk(0, "wrap_top_continue2", mk(4, 26, 4, 27, 4, 28, 4, 29, 0, 1));
    chk(1, "wall_top_over", vcol(20, 0, 1, 2));
    step();
    chk(1, "over_one_tick", vcol(20, 0, 1, 2));

    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk2("async_reset_mid_over", hrow(20, 15, 0, 0));
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;

    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d pending, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
